// File: rtl/full_adder_core_pkg.sv
// Shared helpers for the full_adder_core ripple adder.
// Holds the carry majority function used by every bit cell.
package full_adder_core_pkg;

  function automatic logic maj3(
    input logic x,
    input logic y,
    input logic z
  );
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/full_adder_core_fa_bit_cell.sv
// One-bit full adder leaf cell.
// Pure combinational sum and carry for one ripple stage.
module fa_bit_cell
  import full_adder_core_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = maj3(a, b, ci);

endmodule

// File: rtl/full_adder_core.sv
// Ripple-carry adder with combinational result
// and a one-cycle registered copy for pipelined consumers.
module full_adder_core
  import full_adder_core_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             out_valid
);

  logic [WIDTH:0] c;

  assign c[0] = cin;
  assign cout = c[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_bit_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  // Capture the live result on valid cycles; valid is a delayed in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      cout_q    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_q  <= sum;
        cout_q <= cout;
      end
    end
  end

endmodule

// File: tb/tb_full_adder_core.sv
// Directed and random checks for full_adder_core
// at WIDTH=1 and WIDTH=8.
module tb_full_adder_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic a1, b1, cin1, iv1;
  logic s1, co1, sq1, coq1, ov1;

  logic [7:0] a8, b8, s8, sq8;
  logic cin8, iv8, co8, coq8, ov8;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic a;
    logic b;
    logic cin;
    logic s;
    logic co;
  } v1_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } v8_t;

  v1_t tv1[8];
  v8_t tv8[8];

  full_adder_core #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .in_valid  (iv1),
    .sum       (s1),
    .cout      (co1),
    .sum_q     (sq1),
    .cout_q    (coq1),
    .out_valid (ov1)
  );

  full_adder_core #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .in_valid  (iv8),
    .sum       (s8),
    .cout      (co8),
    .sum_q     (sq8),
    .cout_q    (coq8),
    .out_valid (ov8)
  );

  task automatic check(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    logic [8:0] ref9;
    logic [7:0] exp_sq;
    logic       exp_coq;
    logic       exp_ov;
    logic       nv;

    tv1[0] = '{0, 0, 0, 0, 0};
    tv1[1] = '{0, 0, 1, 1, 0};
    tv1[2] = '{0, 1, 0, 1, 0};
    tv1[3] = '{0, 1, 1, 0, 1};
    tv1[4] = '{1, 0, 0, 1, 0};
    tv1[5] = '{1, 0, 1, 0, 1};
    tv1[6] = '{1, 1, 0, 0, 1};
    tv1[7] = '{1, 1, 1, 1, 1};

    tv8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tv8[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tv8[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tv8[3] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    tv8[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tv8[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    tv8[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    tv8[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

    rst_n = 1'b0;
    a1 = 0; b1 = 0; cin1 = 0; iv1 = 0;
    a8 = '0; b8 = '0; cin8 = 0; iv8 = 0;

    #12;
    check("rst sum_q w1", 64'(sq1), 64'd0);
    check("rst cout_q w1", 64'(coq1), 64'd0);
    check("rst out_valid w1", 64'(ov1), 64'd0);
    check("rst sum_q w8", 64'(sq8), 64'd0);
    check("rst out_valid w8", 64'(ov8), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      a1 = tv1[i].a;
      b1 = tv1[i].b;
      cin1 = tv1[i].cin;
      #10;
      check($sformatf("w1 sum vec%0d", i), 64'(s1), 64'(tv1[i].s));
      check($sformatf("w1 cout vec%0d", i), 64'(co1), 64'(tv1[i].co));
    end

    @(negedge clk);
    a1 = 1; b1 = 0; cin1 = 0; iv1 = 1;
    @(posedge clk);
    #1;
    check("lat sum_q", 64'(sq1), 64'd1);
    check("lat cout_q", 64'(coq1), 64'd0);
    check("lat out_valid", 64'(ov1), 64'd1);

    @(negedge clk);
    iv1 = 0; a1 = 1; b1 = 1;
    @(posedge clk);
    #1;
    check("drop out_valid", 64'(ov1), 64'd0);
    check("hold sum_q", 64'(sq1), 64'd1);
    check("hold cout_q", 64'(coq1), 64'd0);

    @(negedge clk);
    a1 = 1; b1 = 0; cin1 = 0; iv1 = 1;
    @(posedge clk);
    #1;
    check("pre-rst out_valid", 64'(ov1), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async sum_q", 64'(sq1), 64'd0);
    check("async cout_q", 64'(coq1), 64'd0);
    check("async out_valid", 64'(ov1), 64'd0);
    a1 = 0; b1 = 1; cin1 = 1;
    #1;
    check("rst comb sum", 64'(s1), 64'd0);
    check("rst comb cout", 64'(co1), 64'd1);
    @(posedge clk);
    #1;
    check("rst discard valid", 64'(ov1), 64'd0);
    check("rst discard sum_q", 64'(sq1), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    iv1 = 0;
    @(posedge clk);
    #1;
    check("post-rst out_valid", 64'(ov1), 64'd0);
    check("post-rst sum_q", 64'(sq1), 64'd0);

    for (int i = 0; i < 8; i++) begin
      a8 = tv8[i].a;
      b8 = tv8[i].b;
      cin8 = tv8[i].cin;
      #10;
      check($sformatf("w8 sum vec%0d", i), 64'(s8), 64'(tv8[i].s));
      check($sformatf("w8 cout vec%0d", i), 64'(co8), 64'(tv8[i].co));
    end

    exp_sq = 8'h00;
    exp_coq = 1'b0;
    exp_ov = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      cin8 = 1'($urandom_range(0, 1));
      iv8 = 1'($urandom_range(0, 1));
      #1;
      ref9 = {1'b0, a8} + {1'b0, b8} + {8'b0, cin8};
      check("rand comb", 64'({co8, s8}), 64'(ref9));
      nv = iv8;
      @(posedge clk);
      #1;
      exp_ov = nv;
      if (nv) begin
        exp_sq = ref9[7:0];
        exp_coq = ref9[8];
      end
      check("rand out_valid", 64'(ov8), 64'(exp_ov));
      check("rand sum_q", 64'(sq8), 64'(exp_sq));
      check("rand cout_q", 64'(coq8), 64'(exp_coq));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/full_adder_core.md
Name: full_adder_core

Overview:
- Parameterizable ripple-carry adder. Computes a + b + cin with a zero-latency combinational result (sum, cout).
- Also provides a one-cycle registered copy of the result (sum_q, cout_q, out_valid) for pipelined consumers.
- Default WIDTH=1 is the classic 1-bit full adder. It is used as the arithmetic leaf cell in datapath and adder-tree blocks.

Parameters:
- WIDTH, 1, bit width of operands a, b and result sum; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock for the registered outputs only.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry in.
- in_valid  input  1  qualifies a/b/cin for capture into the output registers.
- sum  output  WIDTH  combinational sum, (a+b+cin) mod 2^WIDTH.
- cout  output  1  combinational carry out, bit WIDTH of a+b+cin.
- sum_q  output  WIDTH  registered sum.
- cout_q  output  1  registered carry out.
- out_valid  output  1  high for one cycle after an in_valid cycle.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low. Reset only affects registered outputs.
- Combinational path:
  - {cout, sum} = a + b + cin, computed in WIDTH+1 bits.
  - No clock or reset dependence; sum/cout are valid within the same delta/settle window as input changes.
  - Per bit i: s_i = a_i ^ b_i ^ c_i; c_{i+1} = (a_i & b_i) | (a_i & c_i) | (b_i & c_i); c_0 = cin; cout = c_WIDTH.
- WIDTH=1 truth table (a b cin -> sum cout): 000->0 0, 001->1 0, 010->1 0, 011->0 1, 100->1 0, 101->0 1, 110->0 1, 111->1 1.
- Registered path:
  - On a rising clk edge with in_valid=1: sum_q<=sum, cout_q<=cout, out_valid<=1. Latency is exactly 1 cycle.
  - On a rising clk edge with in_valid=0: sum_q/cout_q hold; out_valid<=0.
- Reset:
  - While rst_n=0: sum_q=0, cout_q=0, out_valid=0, asserted immediately without waiting for clk.
  - Deassertion is synchronized by the user. The first edge after deassertion behaves normally.
  - Reset mid-operation discards any pending capture. sum/cout continue to track the inputs during reset.
- Boundaries:
  - All-ones + all-ones + cin=1 gives sum=all-ones, cout=1.
  - Overflow wraps mod 2^WIDTH, with the carry reported on cout.
  - X on any input propagates to the outputs; no masking.
- No handshake backpressure. out_valid is purely a delayed in_valid.

Decomposition:
- Shared package: none required. WIDTH stays a module parameter.
- One sub-module, fa_bit_cell (a, b, ci -> s, co, 1-bit, pure combinational). Instantiate WIDTH times in a generate ripple chain.
- The register stage lives in full_adder_core.

Test Plan:
- WIDTH=1 exhaustive: apply all 8 {a,b,cin} combinations, 10 ns each. For example 1,1,0 -> sum=0 cout=1; 1,0,1 -> 0/1; 0,1,0 -> 1/0; 0,0,0 -> 0/0; 1,1,1 -> 1/1. Check sum/cout 10 ns after each change.
- Registered latency: in_valid=1 with a=1,b=0,cin=0 at edge N -> sum_q=1, cout_q=0, out_valid=1 after edge N. Drop in_valid -> out_valid=0 at edge N+1 and sum_q holds 1.
- Async reset: assert rst_n=0 between edges while sum_q=1/out_valid=1 -> sum_q, cout_q and out_valid go to 0 immediately. Combinational sum still follows the inputs.
- WIDTH=8 overflow: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- WIDTH=8 random: 1000 random a/b/cin vectors -> {cout,sum} equals the 9-bit reference a+b+cin. Registered outputs equal the prior cycle's combinational result whenever out_valid=1.
